// File: rtl/led_arb_pkg.sv
// led_arbiter shared types and helpers.
// Holds the FSM state type, default sizes and the pattern slice helper.
package led_arb_pkg;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_LED_W       = 8;
  localparam int DEF_SLOT_CYCLES = 100_000_000;

  // Widest supported pattern bus: 8 requesters of up to 64 bits each.
  localparam int MAX_W    = 64;
  localparam int MAX_BITS = 512;

  function automatic logic [MAX_W-1:0] get_pattern(
    input logic [MAX_BITS-1:0] pv,
    input int                  idx,
    input int                  w
  );
    return MAX_W'(pv >> (idx * w));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first candidate after i_ptr, with wrap.
// Candidates are i_req with i_excl masked out.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic [N-1:0]  i_excl,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    int c;
    c       = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(i_ptr) + k) % N;
      if (!o_valid && w_cand[c]) begin
        o_idx   = PW'(c);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin time-slot arbiter sharing the user LEDs between sources.
// The owner keeps the LEDs for a full slot unless it releases early.
import led_arb_pkg::*;

module led_arbiter #(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int LED_W       = DEF_LED_W,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LED_W-1:0] pattern,
  output logic [N_REQ-1:0]       grant,
  output logic [LED_W-1:0]       led,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(SLOT_CYCLES - 1);

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [LED_W-1:0] r_led;
  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_ptr;

  logic [N_REQ-1:0] w_excl;
  logic [PW-1:0]    w_idx;
  logic             w_valid;
  logic             w_own_req;
  logic [LED_W-1:0] w_win_pat;
  logic [LED_W-1:0] w_own_pat;

  // In HOLD the pointer is the owner, so excluding it yields "next after owner".
  assign w_excl    = (r_state == HOLD) ? r_grant : '0;
  assign w_own_req = |(req & r_grant);

  assign w_win_pat = LED_W'(get_pattern(MAX_BITS'(pattern), int'(w_idx), LED_W));
  assign w_own_pat = LED_W'(get_pattern(MAX_BITS'(pattern), int'(r_ptr), LED_W));

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_excl  (w_excl),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= PW'(N_REQ - 1);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= HOLD;
            r_grant <= N_REQ'(1) << w_idx;
            r_led   <= w_win_pat;
            r_busy  <= 1'b1;
            r_cnt   <= RELOAD;
            r_ptr   <= w_idx;
          end
        end
        HOLD: begin
          if ((!w_own_req || r_cnt == '0) && w_valid) begin
            r_grant <= N_REQ'(1) << w_idx;
            r_led   <= w_win_pat;
            r_cnt   <= RELOAD;
            r_ptr   <= w_idx;
          end else if (!w_own_req) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_led <= w_own_pat;
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign led   = r_led;
  assign busy  = r_busy;

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter (N_REQ=4, LED_W=8, SLOT_CYCLES=4).
// Driver pushes expected post-edge outputs; monitor pops and compares.
module tb_led_arbiter;

  logic        clk;
  logic        nreset;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        busy;

  typedef struct {
    logic [3:0] g;
    logic [7:0] l;
    logic       b;
    string      nm;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pat;
  int          n_run;
  int          n_fail;

  led_arbiter #(
    .N_REQ       (4),
    .LED_W       (8),
    .SLOT_CYCLES (4)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .led     (led),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic       rn,
    input logic [3:0] rq,
    input logic [3:0] eg,
    input logic [7:0] el,
    input logic       eb,
    input string      nm
  );
    exp_t e;
    @(negedge clk);
    nreset  = rn;
    req     = rq;
    pattern = pat;
    e.g  = eg;
    e.l  = el;
    e.b  = eb;
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per active edge, sampled 1 unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_run++;
        if (grant !== e.g || led !== e.l || busy !== e.b) begin
          n_fail++;
          $display("FAIL %s: got grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                   e.nm, grant, led, busy, e.g, e.l, e.b);
        end
      end
    end
  end

  initial begin
    n_run   = 0;
    n_fail  = 0;
    nreset  = 1'b0;
    req     = 4'b0000;
    pat     = 32'h44_33_22_11;
    pattern = pat;

    // 1. reset with all requests high, then release
    repeat (3) step(1'b0, 4'b1111, 4'b0000, 8'h00, 1'b0, "rst_hold");
    step(1'b1, 4'b1111, 4'b0001, 8'h11, 1'b1, "rst_release_r0");
    step(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, "rst_to_idle");

    // 2. single requester across renewals
    pat[15:8] = 8'hA5;
    step(1'b1, 4'b0010, 4'b0010, 8'hA5, 1'b1, "single_grant");
    repeat (9) step(1'b1, 4'b0010, 4'b0010, 8'hA5, 1'b1, "single_renew");
    step(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, "single_release");

    // 3. contention from fresh reset
    pat = 32'h00_22_00_11;
    step(1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, "cont_reset");
    repeat (4) step(1'b1, 4'b0101, 4'b0001, 8'h11, 1'b1, "cont_slot0");
    repeat (4) step(1'b1, 4'b0101, 4'b0100, 8'h22, 1'b1, "cont_slot2");
    step(1'b1, 4'b0101, 4'b0001, 8'h11, 1'b1, "cont_back0");
    step(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, "cont_idle");

    // 4a. early release with a pending requester
    pat = 32'h3C_00_5A_00;
    step(1'b1, 4'b0010, 4'b0010, 8'h5A, 1'b1, "rel_grant1");
    step(1'b1, 4'b1010, 4'b0010, 8'h5A, 1'b1, "rel_r3_waits");
    step(1'b1, 4'b1000, 4'b1000, 8'h3C, 1'b1, "rel_to_r3");
    step(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, "rel_r3_idle");

    // 4b. early release with nothing pending
    step(1'b1, 4'b0010, 4'b0010, 8'h5A, 1'b1, "rel_grant1b");
    step(1'b1, 4'b0010, 4'b0010, 8'h5A, 1'b1, "rel_hold1b");
    step(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, "rel_to_idle");

    // 5. owner pattern tracking, non-owner ignored
    pat[7:0] = 8'h0F;
    step(1'b1, 4'b0001, 4'b0001, 8'h0F, 1'b1, "pat_grant0");
    pat[7:0] = 8'hF0;
    step(1'b1, 4'b0001, 4'b0001, 8'hF0, 1'b1, "pat_owner_chg");
    pat[23:16] = 8'h77;
    step(1'b1, 4'b0001, 4'b0001, 8'hF0, 1'b1, "pat_other_chg");
    step(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, "pat_idle");

    // 6. reset in the middle of requester 2's slot
    pat = 32'h99_66_00_E1;
    step(1'b1, 4'b0100, 4'b0100, 8'h66, 1'b1, "mid_grant2");
    step(1'b1, 4'b0100, 4'b0100, 8'h66, 1'b1, "mid_hold2");
    step(1'b0, 4'b0100, 4'b0000, 8'h00, 1'b0, "mid_reset");
    step(1'b1, 4'b1001, 4'b0001, 8'hE1, 1'b1, "mid_r0_first");
    step(1'b1, 4'b1001, 4'b0001, 8'hE1, 1'b1, "mid_r0_hold");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
Time-slot arbiter that shares the board's 8 user LEDs between several pattern sources (blinker, status, debug, and similar).
- Each requester raises `req` and presents a pattern.
- The arbiter grants round-robin, one fixed-length slot at a time, and drives the winning pattern onto `led`.
- Sits in the PLL output clock domain between the pattern generators and the top-level `led` pins.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- LED_W, 8, LED vector width
- SLOT_CYCLES, 100_000_000, slot length in clk cycles (0.25 s at 400 MHz); must be >= 2

Ports:
- clk  input  1  system clock (PLL output)
- nreset  input  1  reset; one clock, synchronous, active-low
- req  input  N_REQ  per-requester request, level-sensitive
- pattern  input  N_REQ*LED_W  packed patterns; requester i occupies bits [i*LED_W +: LED_W]
- grant  output  N_REQ  one-hot current owner, all-zero when idle
- led  output  LED_W  displayed pattern
- busy  output  1  high while any grant is active

Behaviour:
- All outputs are registered.
- Reset (nreset low at a clk edge):
  - grant=0, led=0, busy=0, state=IDLE, slot counter=0.
  - Round-robin pointer is set to N_REQ-1, so requester 0 has first priority.
  - Reset applied mid-slot takes effect at the next edge; the slot is abandoned with no further LED update.
- States: IDLE, HOLD.
- IDLE:
  - led=0, grant=0.
  - If any req is sampled high, pick the winner on the same edge: first req high scanning from pointer+1 upward with wrap.
  - On that edge: grant=onehot(winner), led=pattern[winner], busy=1, counter=SLOT_CYCLES-1, pointer=winner, go to HOLD.
  - Latency: req high at edge k produces grant and led valid after edge k.
- HOLD, each edge:
  - led <= pattern[owner]. The LED tracks pattern changes with 1-cycle latency.
  - Counter decrements while nonzero.
- HOLD exit conditions, evaluated on each edge in this priority order:
  1. Owner req low (early release): rerun the pick, excluding the owner. If a winner exists, grant it immediately (new slot, counter reloaded). Otherwise go to IDLE: grant=0, led=0, busy=0.
  2. Counter==0 and another req high: rotate to the next winner after the owner with no idle gap. New slot, counter reloaded, pointer updated.
  3. Counter==0 and only the owner requests: renew the slot in place (counter reloaded; grant and led unchanged).
- A slot therefore lasts exactly SLOT_CYCLES edges under contention.
- Simultaneous requests in IDLE resolve by pointer order.
- A new requester arriving mid-slot waits until the slot expires or the owner releases.
- Pattern bits of non-owners are ignored.
- `grant` is always one-hot or zero; `busy` equals OR(grant).
- Counter width is $clog2(SLOT_CYCLES). No overflow is possible because the counter only counts down from the reload value.

Decomposition:
- Package led_arb_pkg holds:
  - state enum (IDLE, HOLD)
  - default-parameter localparams
  - a function extracting LED_W bits for index i from the packed pattern
- One natural sub-module, rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector, start pointer, exclude mask.
  - Outputs: winner index, valid.
  - Used for both the IDLE pick and the HOLD rotation.

Test Plan:
Bench uses N_REQ=4, LED_W=8, SLOT_CYCLES=4.
1. Reset: hold nreset low 3 cycles with req=1111 -> grant=0000, led=00, busy=0 throughout. Release -> grant=0001 and led=pattern0 on the first edge.
2. Single requester: req=0010 held, pattern1=A5 -> grant=0010 and led=A5 after one edge. Grant stays continuous across slot renewals with no glitch to 0.
3. Contention: from IDLE, req=0101 with pattern0=11 and pattern2=22 -> grant=0001 for 4 cycles, then 0100 for 4 cycles, then 0001. No idle cycles between slots.
4. Early release: owner req1 drops on cycle 2 of its slot.
   - With req3 pending -> grant=1000 on the next edge and led=pattern3.
   - With nothing pending -> grant=0000, led=00, busy=0.
5. Pattern update: owner pattern changes 0F->F0 mid-slot -> led shows F0 exactly one edge later. Changes to a non-owner pattern do not affect led.
6. Reset mid-slot: assert nreset low during requester 2's slot -> all outputs zero at the next edge. Release with req=1001 -> requester 0 granted first.
